maze_walker: RTL
================

# maze_walker

Depth-first maze solver that drives the read/write port of the 16x16 maze memory as its initiator. On `start` it walks from cell (0,0) toward (15,15), marking every entered cell in memory and keeping its route on an internal direction stack. It streams each forward or backtrack move to downstream logic, then reports `done` or `fail`. It sits between the top-level controller and the maze memory.

## Interface
- No parameters; grid is fixed 16x16, goal fixed at (15,15), start fixed at (0,0).
- `clk`  in  1  system clock, rising edge
- `rst`  in  1  asynchronous, active-low reset
- `start`  in  1  one-cycle request; sampled only in IDLE
- `mode`  in  1  memory read data, combinational, valid in the same cycle `read`=1; 0=free, 1=wall/visited
- `read`  out  1  memory read strobe
- `write`  out  1  memory write strobe; memory commits on the next rising `clk`
- `d_in`  out  1  memory write data; always 1 when `write`=1
- `X`, `Y`  out  4 each  memory cell address
- `busy`  out  1  high from the cycle after `start` is accepted until DONE/FAIL
- `done`, `fail`  out  1 each  level flags; cleared on next accepted `start`
- `move_valid`  out  1  one-cycle pulse per position change
- `move_dir`  out  2  direction moved: 0=up(Y+1), 1=right(X+1), 2=left(X-1), 3=down(Y-1)
- `move_back`  out  1  qualifies `move_dir`: 1 = backtrack step (opposite of popped dir)
- `path_len`  out  8  current stack depth; equals route length at DONE

## Operation
- Reset (`rst`=0, any time, including mid-walk): state IDLE; all outputs 0; stack pointer, position and dir index 0. Memory contents written so far are not undone.
- State IDLE: `start`=1 -> clear `done`/`fail`, pos=(0,0), sp=0 -> CHK0. `start` outside IDLE is ignored.
- State CHK0: `read`=1 at (0,0). If `mode`=1 -> FAIL. Otherwise -> MARK.
- State MARK: `write`=1, `d_in`=1 at current pos. If pos=(15,15) -> DONE. Otherwise dir=0 -> PROBE.
- State PROBE: one cycle per direction in the fixed order 0,1,2,3.
  - Out-of-bounds neighbour: no read, dir+1.
  - In-bounds neighbour: `read`=1 with X/Y at the neighbour; `mode`=1 -> dir+1; `mode`=0 -> ADVANCE.
  - dir exhausted (past 3): sp=0 -> FAIL; else -> BACK.
- State ADVANCE: push dir, sp+1, pos moves by dir, `move_valid`=1, `move_back`=0 -> MARK.
- State BACK: pop d, sp-1, pos moves opposite of d, `move_valid`=1, `move_dir`=opposite(d), `move_back`=1 -> PROBE with dir=d+1 (d=3 means exhausted).
- DONE / FAIL: corresponding flag =1, `busy`=0; wait for next `start`.
- `read` and `write` are never high in the same cycle. Outside CHK0/MARK/PROBE both are 0 and X/Y hold the current position.
- Stack: 256 x 2 bit. sp never exceeds 255 because each push enters an unvisited cell.

## Timing
- All outputs are registered, except `read`/X/Y during PROBE. These are decoded from the state/dir registers and are glitch-free after the clock edge.
- `mode` is consumed in the same cycle it is read; there is no read latency.
- Cycles per cell: forward entry = MARK (1) + probes tried + ADVANCE (1). Backtrack = BACK (1), then resume probing.
- `done`/`fail` rise in the first cycle of DONE/FAIL, together with the `busy` fall.

## Test plan
- All-zero map, pulse `start` -> 30 ADVANCE pulses (15 up, then 15 right, `move_back`=0); `busy` high exactly 107 cycles; `done`=1, `path_len`=30; all 31 route cells read back as 1.
- Map with (0,0)=1 -> `fail`=1 after 1 busy cycle; no `write` ever asserted; `move_valid` never pulses.
- Map with (0,1)=1 and (1,0)=1 -> (0,0) written 1, probes up/right blocked, left/down out of bounds -> `fail`=1, `path_len`=0.
- Map with (0,3)=1 and (1,2)=1 -> walker reaches (0,2), dead-ends, emits `move_valid` with `move_dir`=3, `move_back`=1 to (0,1); then advances right to (1,1); reaches goal with `done`=1.
- Assert `rst`=0 mid-walk on the all-zero map -> all outputs 0 immediately (asynchronous); a new `start` restarts from (0,0). Because (0,0) is already marked, the walk ends `fail`=1 via CHK0.
- `start` held high throughout a walk -> exactly one walk per IDLE visit; a pulse during `busy` has no effect.

Source files
------------

// File: rtl/maze_walker.sv
// rtl/maze_walker.sv - depth-first 16x16 maze solver driving the maze memory port
//
// Walks from (0,0) toward (15,15), marking entered cells and keeping the
// route on an internal 256x2 direction stack. Each position change is
// reported on the move_* outputs.
//
// Ports:
//   i_clk          system clock, rising edge
//   i_rst_n        asynchronous active-low reset
//   i_start        one-cycle walk request, accepted only while not busy
//   i_mode         memory read data (0=free, 1=wall/visited), same-cycle
//   o_read         memory read strobe
//   o_write        memory write strobe (commits on next rising clock)
//   o_d_in         memory write data, 1 whenever o_write=1
//   o_x, o_y       memory cell address
//   o_busy         walk in progress
//   o_done, o_fail level result flags, cleared by the next accepted start
//   o_move_valid   one-cycle pulse per position change
//   o_move_dir     0=up(Y+1) 1=right(X+1) 2=left(X-1) 3=down(Y-1)
//   o_move_back    1 = backtrack step
//   o_path_len     current stack depth

module maze_walker (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_start,
    input  logic       i_mode,
    output logic       o_read,
    output logic       o_write,
    output logic       o_d_in,
    output logic [3:0] o_x,
    output logic [3:0] o_y,
    output logic       o_busy,
    output logic       o_done,
    output logic       o_fail,
    output logic       o_move_valid,
    output logic [1:0] o_move_dir,
    output logic       o_move_back,
    output logic [7:0] o_path_len
);

    typedef enum logic [2:0] {
        S_IDLE, S_CHK0, S_MARK, S_PROBE, S_ADVANCE, S_BACK, S_DONE, S_FAIL
    } state_t;

    state_t     r_state, w_state_nxt;
    logic [2:0] r_dir,   w_dir_nxt;     // bit 2 set = all four directions tried
    logic [7:0] r_sp,    w_sp_nxt;
    logic [3:0] r_x,     w_x_nxt;
    logic [3:0] r_y,     w_y_nxt;
    logic       r_busy,  w_busy_nxt;
    logic       r_done,  w_done_nxt;
    logic       r_fail,  w_fail_nxt;
    logic       r_read,  w_read_nxt;    // CHK0 read only; probe reads are decoded
    logic       r_write, w_write_nxt;
    logic       r_mv,    w_mv_nxt;
    logic [1:0] r_md,    w_md_nxt;
    logic       r_mb,    w_mb_nxt;

    logic [1:0] r_stack [0:255];
    logic [1:0] w_top;
    logic [1:0] w_back_dir;
    logic [3:0] w_nx, w_ny;
    logic       w_inb;
    logic       w_probe_rd;

    function automatic logic [3:0] f_step_x(input logic [3:0] x, input logic [1:0] d);
        logic [3:0] v;
        v = x;
        if (d == 2'd1) v = x + 4'd1;
        if (d == 2'd2) v = x - 4'd1;
        return v;
    endfunction

    function automatic logic [3:0] f_step_y(input logic [3:0] y, input logic [1:0] d);
        logic [3:0] v;
        v = y;
        if (d == 2'd0) v = y + 4'd1;
        if (d == 2'd3) v = y - 4'd1;
        return v;
    endfunction

    assign w_top      = r_stack[r_sp - 8'd1];
    // Direction encoding makes the opposite direction the bitwise inverse.
    assign w_back_dir = ~w_top;

    // Neighbour of the current cell in the direction being probed.
    always_comb begin
        w_nx  = f_step_x(r_x, r_dir[1:0]);
        w_ny  = f_step_y(r_y, r_dir[1:0]);
        w_inb = 1'b0;
        case (r_dir[1:0])
            2'd0:    w_inb = (r_y != 4'd15);
            2'd1:    w_inb = (r_x != 4'd15);
            2'd2:    w_inb = (r_x != 4'd0);
            default: w_inb = (r_y != 4'd0);
        endcase
    end

    assign w_probe_rd = (r_state == S_PROBE) && !r_dir[2] && w_inb;

    assign o_read       = r_read | w_probe_rd;
    assign o_write      = r_write;
    assign o_d_in       = r_write;
    assign o_x          = w_probe_rd ? w_nx : r_x;
    assign o_y          = w_probe_rd ? w_ny : r_y;
    assign o_busy       = r_busy;
    assign o_done       = r_done;
    assign o_fail       = r_fail;
    assign o_move_valid = r_mv;
    assign o_move_dir   = r_md;
    assign o_move_back  = r_mb;
    assign o_path_len   = r_sp;

    always_comb begin
        w_state_nxt = r_state;
        w_dir_nxt   = r_dir;
        w_sp_nxt    = r_sp;
        w_x_nxt     = r_x;
        w_y_nxt     = r_y;
        w_busy_nxt  = r_busy;
        w_done_nxt  = r_done;
        w_fail_nxt  = r_fail;
        w_read_nxt  = 1'b0;
        w_write_nxt = 1'b0;
        w_mv_nxt    = 1'b0;
        w_md_nxt    = r_md;
        w_mb_nxt    = r_mb;
        case (r_state)
            S_IDLE, S_DONE, S_FAIL: begin
                if (i_start) begin
                    w_state_nxt = S_CHK0;
                    w_done_nxt  = 1'b0;
                    w_fail_nxt  = 1'b0;
                    w_x_nxt     = 4'd0;
                    w_y_nxt     = 4'd0;
                    w_sp_nxt    = 8'd0;
                    w_busy_nxt  = 1'b1;
                    w_read_nxt  = 1'b1;
                end
            end
            S_CHK0: begin
                if (i_mode) begin
                    w_state_nxt = S_FAIL;
                    w_fail_nxt  = 1'b1;
                    w_busy_nxt  = 1'b0;
                end else begin
                    w_state_nxt = S_MARK;
                    w_write_nxt = 1'b1;
                end
            end
            S_MARK: begin
                if (r_x == 4'd15 && r_y == 4'd15) begin
                    w_state_nxt = S_DONE;
                    w_done_nxt  = 1'b1;
                    w_busy_nxt  = 1'b0;
                end else begin
                    w_state_nxt = S_PROBE;
                    w_dir_nxt   = 3'd0;
                end
            end
            S_PROBE: begin
                if (r_dir[2]) begin
                    if (r_sp == 8'd0) begin
                        w_state_nxt = S_FAIL;
                        w_fail_nxt  = 1'b1;
                        w_busy_nxt  = 1'b0;
                    end else begin
                        w_state_nxt = S_BACK;
                        w_mv_nxt    = 1'b1;
                        w_md_nxt    = w_back_dir;
                        w_mb_nxt    = 1'b1;
                    end
                end else if (w_inb && !i_mode) begin
                    w_state_nxt = S_ADVANCE;
                    w_mv_nxt    = 1'b1;
                    w_md_nxt    = r_dir[1:0];
                    w_mb_nxt    = 1'b0;
                end else begin
                    w_dir_nxt = r_dir + 3'd1;
                end
            end
            S_ADVANCE: begin
                w_sp_nxt    = r_sp + 8'd1;
                w_x_nxt     = w_nx;
                w_y_nxt     = w_ny;
                w_state_nxt = S_MARK;
                w_write_nxt = 1'b1;
            end
            S_BACK: begin
                w_sp_nxt    = r_sp - 8'd1;
                w_x_nxt     = f_step_x(r_x, w_back_dir);
                w_y_nxt     = f_step_y(r_y, w_back_dir);
                // Resume with the direction after the one just undone.
                w_dir_nxt   = {1'b0, w_top} + 3'd1;
                w_state_nxt = S_PROBE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
            r_dir   <= 3'd0;
            r_sp    <= 8'd0;
            r_x     <= 4'd0;
            r_y     <= 4'd0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_fail  <= 1'b0;
            r_read  <= 1'b0;
            r_write <= 1'b0;
            r_mv    <= 1'b0;
            r_md    <= 2'd0;
            r_mb    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_dir   <= w_dir_nxt;
            r_sp    <= w_sp_nxt;
            r_x     <= w_x_nxt;
            r_y     <= w_y_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
            r_fail  <= w_fail_nxt;
            r_read  <= w_read_nxt;
            r_write <= w_write_nxt;
            r_mv    <= w_mv_nxt;
            r_md    <= w_md_nxt;
            r_mb    <= w_mb_nxt;
        end
    end

    // Stack contents need no reset; only entries below sp are ever read.
    always_ff @(posedge i_clk) begin
        if (r_state == S_ADVANCE) begin
            r_stack[r_sp] <= r_dir[1:0];
        end
    end

endmodule
